axi_vip_exdes_scoreboard: RTL and testbench
===========================================

# axi_vip_exdes_scoreboard

In-order AXI transaction scoreboard for the VIP example design. It sits beside the master–passthrough–slave chain. It accepts completed transactions reported by the master-side monitor and queues them as expected entries. It compares each transaction reported by the slave-side monitor against the oldest expected entry and keeps match/mismatch statistics and error flags.

## Interface
- ADDR_W, 32, address width of reported transactions
- DATA_W, 32, data width (first beat only is compared)
- ID_W, 4, AXI ID width
- DEPTH, 16, expected-queue depth (power of 2, ≥2)
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear of queue, counters, flags (same effect as reset)
- mst_valid  in  1  master-monitor transaction valid
- mst_ready  out  1  queue can accept; = ~full & ~reset
- mst_write, mst_id, mst_addr, mst_data, mst_resp(2)  in  expected transaction fields
- slv_valid  in  1  slave-monitor transaction valid
- slv_ready  out  1  constant 1 (slave reports never stalled)
- slv_write, slv_id, slv_addr, slv_data, slv_resp(2)  in  observed transaction fields
- match_pulse  out  1  one-cycle pulse: compared transaction matched
- mismatch_pulse  out  1  one-cycle pulse: mismatch or orphan
- mismatch_mask  out  5  fields differing on last mismatch {write,id,addr,data,resp}, bit4=write
- orphan_err  out  1  sticky: slave transaction arrived with queue empty
- overflow_err  out  1  sticky: mst_valid high while mst_ready low
- first_err_addr  out  ADDR_W  slv_addr of first mismatch/orphan since reset/clear
- match_count, mismatch_count  out  16  saturating counters
- pending  out  log2(DEPTH)+1  entries in queue
- idle  out  1  pending == 0

## Operation
- Push: on the mst_valid & mst_ready edge, append {write,id,addr,data,resp} to FIFO tail.
- Pop/compare: on slv_valid, if the FIFO is non-empty, compare all five fields with the head (show-ahead, combinational read) and pop the head.
  - All equal → match.
  - Any field differs → mismatch; mismatch_mask records the differing fields.
- Orphan: slv_valid with the FIFO empty (as sampled at the start of the cycle) → mismatch. Sets orphan_err and mismatch_mask = 5'b11111. Nothing is popped.
- An entry pushed in the same cycle is never compared with a simultaneous slave report.
- Simultaneous push and pop on a non-empty queue: both happen; pending is unchanged.
- Full: mst_ready = 0; a push attempt sets overflow_err and drops that transaction. A same-cycle pop does not free the slot for that cycle.
- first_err_addr loads only on the first mismatch/orphan; it holds until reset or clear.
- Counters saturate at 16'hFFFF; they never wrap.
- Reset/clear, including mid-stream:
  - queue emptied, counters 0, sticky flags 0, mismatch_mask 0, first_err_addr 0, pulses 0.
  - Inputs in that cycle are ignored.
  - clear has priority over push/pop.

## Timing
- Reset values: mst_ready 0 during reset, 1 the cycle after. slv_ready 1. All other outputs 0; idle 1.
- Compare latency: slave handshake in cycle N → match_pulse/mismatch_pulse high in cycle N+1 only. mismatch_mask, counters, orphan_err and first_err_addr update at the same edge.
- overflow_err is visible the cycle after the rejected push.
- pending/idle update the cycle after push/pop.
- mst_ready deasserts the cycle after the DEPTH-th entry is pushed. It reasserts the cycle after a pop from full.
- Back-to-back transactions every cycle sustain one push and one compare per cycle.

## Test plan
- Reset then idle: idle=1, pending=0, mst_ready=1 the cycle after reset falls, all counters 0.
- Push write id=3 addr=0x1000 data=0xDEADBEEF resp=0, then identical slave report → match_pulse 1 cycle later, match_count=1, idle=1.
- Push addr=0x2000 data=0x11, slave reports data=0x12 → mismatch_count=1, mismatch_mask=5'b00010, first_err_addr=0x2000. A second mismatch at addr=0x3000 leaves first_err_addr unchanged.
- Slave report with empty queue, addr=0x40 → orphan_err=1, mismatch_mask=5'b11111, mismatch_count increments, pending stays 0.
- Fill DEPTH=16 entries → mst_ready=0, pending=16. A 17th push sets overflow_err. A simultaneous push+pop while full: pop occurs, push dropped, pending=15.
- Assert clear mid-stream with pending=5 and counters non-zero → next cycle all zero, idle=1. 70000 matching pairs → match_count holds at 0xFFFF.

Source files
------------

// File: rtl/axi_vip_exdes_scoreboard.sv
// In-order AXI transaction scoreboard for the VIP example design.
// Master-side monitor reports are queued as expected entries. Each slave-side
// report is compared against the oldest entry, which is then popped.
// Match/mismatch statistics and sticky error flags are maintained alongside.
module axi_vip_exdes_scoreboard #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  // Master-side monitor (expected transactions)
  input  logic                      mst_valid_i,
  output logic                      mst_ready_o,
  input  logic                      mst_write_i,
  input  logic [ID_W-1:0]           mst_id_i,
  input  logic [ADDR_W-1:0]         mst_addr_i,
  input  logic [DATA_W-1:0]         mst_data_i,
  input  logic [1:0]                mst_resp_i,
  // Slave-side monitor (observed transactions)
  input  logic                      slv_valid_i,
  output logic                      slv_ready_o,
  input  logic                      slv_write_i,
  input  logic [ID_W-1:0]           slv_id_i,
  input  logic [ADDR_W-1:0]         slv_addr_i,
  input  logic [DATA_W-1:0]         slv_data_i,
  input  logic [1:0]                slv_resp_i,
  // Results and statistics
  output logic                      match_pulse_o,
  output logic                      mismatch_pulse_o,
  output logic [4:0]                mismatch_mask_o,
  output logic                      orphan_err_o,
  output logic                      overflow_err_o,
  output logic [ADDR_W-1:0]         first_err_addr_o,
  output logic [15:0]               match_count_o,
  output logic [15:0]               mismatch_count_o,
  output logic [$clog2(DEPTH):0]    pending_o,
  output logic                      idle_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 1 + ID_W + ADDR_W + DATA_W + 2;

  // Queue storage and pointers
  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Result and statistics state
  logic              match_pulse_q, match_pulse_d;
  logic              mismatch_pulse_q, mismatch_pulse_d;
  logic [4:0]        mask_q, mask_d;
  logic              orphan_q, orphan_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic [15:0]       match_cnt_q, match_cnt_d;
  logic [15:0]       mismatch_cnt_q, mismatch_cnt_d;

  logic              full, empty;
  logic              push, pop, orphan_ev, mismatch_ev;
  logic [EntW-1:0]   head;
  logic              head_write;
  logic [ID_W-1:0]   head_id;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        head_resp;
  logic [4:0]        diff;

  // Queue status and handshake decode
  always_comb begin
    full        = (count_q == CntW'(DEPTH));
    empty       = (count_q == '0);
    mst_ready_o = ~full & ~rst_i;
    slv_ready_o = 1'b1;
    // Clear discards all inputs of its cycle; reset does so via the flop reset.
    push        = mst_valid_i & mst_ready_o & ~clear_i;
    pop         = slv_valid_i & ~empty & ~clear_i;
    orphan_ev   = slv_valid_i & empty & ~clear_i;
  end

  // Show-ahead head read and field-wise comparison
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_write = head[EntW-1];
    head_id    = head[EntW-2 -: ID_W];
    head_addr  = head[2+DATA_W +: ADDR_W];
    head_data  = head[2 +: DATA_W];
    head_resp  = head[1:0];
    diff       = {head_write != slv_write_i,
                  head_id    != slv_id_i,
                  head_addr  != slv_addr_i,
                  head_data  != slv_data_i,
                  head_resp  != slv_resp_i};
    mismatch_ev = (pop & (diff != 5'b0)) | orphan_ev;
  end

  // Queue pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Compare results, sticky flags and saturating statistics next state
  always_comb begin
    match_pulse_d    = pop & (diff == 5'b0);
    mismatch_pulse_d = mismatch_ev;
    mask_d           = mask_q;
    orphan_d         = orphan_q | orphan_ev;
    overflow_d       = overflow_q | (mst_valid_i & ~mst_ready_o & ~clear_i);
    first_err_d      = first_err_q;
    match_cnt_d      = match_cnt_q;
    mismatch_cnt_d   = mismatch_cnt_q;

    if (orphan_ev) begin
      mask_d = 5'b11111;
    end else if (mismatch_ev) begin
      mask_d = diff;
    end

    // A zero mismatch count means no error has been recorded yet (it saturates, never wraps).
    if (mismatch_ev && (mismatch_cnt_q == 16'h0)) begin
      first_err_d = slv_addr_i;
    end

    if (match_pulse_d && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_d = match_cnt_q + 16'd1;
    end
    if (mismatch_ev && (mismatch_cnt_q != 16'hFFFF)) begin
      mismatch_cnt_d = mismatch_cnt_q + 16'd1;
    end
  end

  // Control and statistics state; reset and clear share one synchronous path
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      match_pulse_q    <= 1'b0;
      mismatch_pulse_q <= 1'b0;
      mask_q           <= '0;
      orphan_q         <= 1'b0;
      overflow_q       <= 1'b0;
      first_err_q      <= '0;
      match_cnt_q      <= '0;
      mismatch_cnt_q   <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      match_pulse_q    <= match_pulse_d;
      mismatch_pulse_q <= mismatch_pulse_d;
      mask_q           <= mask_d;
      orphan_q         <= orphan_d;
      overflow_q       <= overflow_d;
      first_err_q      <= first_err_d;
      match_cnt_q      <= match_cnt_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
    end
  end

  // Queue payload storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {mst_write_i, mst_id_i, mst_addr_i, mst_data_i, mst_resp_i};
    end
  end

  // Output mapping
  always_comb begin
    match_pulse_o    = match_pulse_q;
    mismatch_pulse_o = mismatch_pulse_q;
    mismatch_mask_o  = mask_q;
    orphan_err_o     = orphan_q;
    overflow_err_o   = overflow_q;
    first_err_addr_o = first_err_q;
    match_count_o    = match_cnt_q;
    mismatch_count_o = mismatch_cnt_q;
    pending_o        = count_q;
    idle_o           = (count_q == '0);
  end

endmodule

// File: tb/tb_axi_vip_exdes_scoreboard.sv
// Self-checking bench for axi_vip_exdes_scoreboard: a reference queue model
// predicts each compare result, which is queued and checked when the pulse appears.
module tb_axi_vip_exdes_scoreboard;

  localparam int unsigned Depth = 16;

  typedef struct packed {
    logic        w;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } txn_t;

  typedef struct packed {
    logic       mis;
    logic [4:0] mask;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        mst_valid = 1'b0;
  logic        mst_ready;
  logic        mst_write = 1'b0;
  logic [3:0]  mst_id = '0;
  logic [31:0] mst_addr = '0;
  logic [31:0] mst_data = '0;
  logic [1:0]  mst_resp = '0;
  logic        slv_valid = 1'b0;
  logic        slv_ready;
  logic        slv_write = 1'b0;
  logic [3:0]  slv_id = '0;
  logic [31:0] slv_addr = '0;
  logic [31:0] slv_data = '0;
  logic [1:0]  slv_resp = '0;
  logic        match_pulse, mismatch_pulse;
  logic [4:0]  mismatch_mask;
  logic        orphan_err, overflow_err;
  logic [31:0] first_err_addr;
  logic [15:0] match_count, mismatch_count;
  logic [4:0]  pending;
  logic        idle;

  always #5 clk = ~clk;

  axi_vip_exdes_scoreboard #(
    .ADDR_W (32),
    .DATA_W (32),
    .ID_W   (4),
    .DEPTH  (Depth)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (clear),
    .mst_valid_i      (mst_valid),
    .mst_ready_o      (mst_ready),
    .mst_write_i      (mst_write),
    .mst_id_i         (mst_id),
    .mst_addr_i       (mst_addr),
    .mst_data_i       (mst_data),
    .mst_resp_i       (mst_resp),
    .slv_valid_i      (slv_valid),
    .slv_ready_o      (slv_ready),
    .slv_write_i      (slv_write),
    .slv_id_i         (slv_id),
    .slv_addr_i       (slv_addr),
    .slv_data_i       (slv_data),
    .slv_resp_i       (slv_resp),
    .match_pulse_o    (match_pulse),
    .mismatch_pulse_o (mismatch_pulse),
    .mismatch_mask_o  (mismatch_mask),
    .orphan_err_o     (orphan_err),
    .overflow_err_o   (overflow_err),
    .first_err_addr_o (first_err_addr),
    .match_count_o    (match_count),
    .mismatch_count_o (mismatch_count),
    .pending_o        (pending),
    .idle_o           (idle)
  );

  // Reference model state
  txn_t        model_q[$];
  res_t        exp_q[$];
  logic [15:0] m_match, m_mis;
  logic [4:0]  m_mask;
  logic        m_orphan, m_ovf;
  logic [31:0] m_first;
  bit          chk_en = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    model_q.delete();
    m_match  = '0;
    m_mis    = '0;
    m_mask   = '0;
    m_orphan = 1'b0;
    m_ovf    = 1'b0;
    m_first  = '0;
  endtask

  task automatic check_state();
    check_eq("pending", 64'(pending), 64'(model_q.size()));
    check_eq("idle", 64'(idle), 64'(model_q.size() == 0));
    check_eq("mst_ready", 64'(mst_ready), 64'((model_q.size() < Depth) && !rst));
    check_eq("slv_ready", 64'(slv_ready), 64'd1);
    check_eq("match_count", 64'(match_count), 64'(m_match));
    check_eq("mismatch_count", 64'(mismatch_count), 64'(m_mis));
    check_eq("mismatch_mask", 64'(mismatch_mask), 64'(m_mask));
    check_eq("orphan_err", 64'(orphan_err), 64'(m_orphan));
    check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
    check_eq("first_err_addr", 64'(first_err_addr), 64'(m_first));
  endtask

  // One clock cycle: drive inputs, update the model, then check after the edge.
  task automatic step(input logic mv, input txn_t mt, input logic sv, input txn_t st,
                      input logic clr);
    txn_t       h;
    res_t       r;
    logic [4:0] d;
    logic       rdy;
    mst_valid = mv;
    mst_write = mt.w;
    mst_id    = mt.id;
    mst_addr  = mt.addr;
    mst_data  = mt.data;
    mst_resp  = mt.resp;
    slv_valid = sv;
    slv_write = st.w;
    slv_id    = st.id;
    slv_addr  = st.addr;
    slv_data  = st.data;
    slv_resp  = st.resp;
    clear     = clr;
    if (rst || clr) begin
      m_reset();
    end else begin
      rdy = (model_q.size() < Depth);
      if (mv && !rdy) m_ovf = 1'b1;
      if (sv) begin
        if (model_q.size() == 0) begin
          d = 5'b11111;
          m_orphan = 1'b1;
        end else begin
          h = model_q.pop_front();
          d = {h.w != st.w, h.id != st.id, h.addr != st.addr, h.data != st.data,
               h.resp != st.resp};
        end
        r.mis  = (d != 5'b0);
        r.mask = d;
        exp_q.push_back(r);
        if (r.mis) begin
          if (m_mis == 16'h0) m_first = st.addr;
          m_mask = d;
          if (m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
        end else if (m_match != 16'hFFFF) begin
          m_match = m_match + 16'd1;
        end
      end
      if (mv && rdy) model_q.push_back(mt);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (chk_en) begin
        check_eq("match_pulse", 64'(match_pulse), 64'(!r.mis));
        check_eq("mismatch_pulse", 64'(mismatch_pulse), 64'(r.mis));
      end
    end else if (chk_en) begin
      check_eq("pulse_idle", 64'({match_pulse, mismatch_pulse}), 64'd0);
    end
    if (chk_en) check_state();
  endtask

  function automatic txn_t mk(input logic w, input logic [3:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
    txn_t t;
    t.w    = w;
    t.id   = id;
    t.addr = addr;
    t.data = data;
    t.resp = resp;
    return t;
  endfunction

  initial begin
    txn_t z, a, b, t;
    z = '0;
    m_reset();

    // Reset: mst_ready low while reset is held, outputs at their reset values
    step(1'b0, z, 1'b0, z, 1'b0);
    step(1'b1, z, 1'b1, z, 1'b0);
    rst = 1'b0;
    step(1'b0, z, 1'b0, z, 1'b0);
    check_eq("ready_after_reset", 64'(mst_ready), 64'd1);

    // Matching write transaction
    a = mk(1'b1, 4'd3, 32'h1000, 32'hDEADBEEF, 2'd0);
    step(1'b1, a, 1'b0, z, 1'b0);
    step(1'b0, z, 1'b1, a, 1'b0);
    step(1'b0, z, 1'b0, z, 1'b0);
    check_eq("first_match_count", 64'(match_count), 64'd1);

    // Data mismatch; second mismatch keeps first_err_addr
    a = mk(1'b0, 4'd1, 32'h2000, 32'h11, 2'd0);
    b = a;
    b.data = 32'h12;
    step(1'b1, a, 1'b0, z, 1'b0);
    step(1'b0, z, 1'b1, b, 1'b0);
    check_eq("data_mask", 64'(mismatch_mask), 64'h02);
    a = mk(1'b0, 4'd2, 32'h3000, 32'h55, 2'd0);
    b = mk(1'b1, 4'd2, 32'h3000, 32'h55, 2'd2);
    step(1'b1, a, 1'b0, z, 1'b0);
    step(1'b0, z, 1'b1, b, 1'b0);
    check_eq("first_err_held", 64'(first_err_addr), 64'h2000);

    // Orphan report on an empty queue
    b = mk(1'b0, 4'd0, 32'h40, 32'h0, 2'd0);
    step(1'b0, z, 1'b1, b, 1'b0);
    check_eq("orphan_mask", 64'(mismatch_mask), 64'h1F);

    // Same-cycle push is not compared with the simultaneous report (orphan)
    a = mk(1'b0, 4'd5, 32'h50, 32'h5, 2'd0);
    step(1'b1, a, 1'b1, a, 1'b0);
    step(1'b0, z, 1'b1, a, 1'b0);

    // Fill to full, overflow, then push+pop while full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, mk(1'b0, 4'(i), 32'h100 + 32'(i), 32'(i * 7), 2'd0), 1'b0, z, 1'b0);
    end
    check_eq("full_pending", 64'(pending), 64'd16);
    step(1'b1, mk(1'b1, 4'hF, 32'hBAD, 32'hBAD, 2'd3), 1'b0, z, 1'b0);
    check_eq("overflow_set", 64'(overflow_err), 64'd1);
    step(1'b1, mk(1'b1, 4'hE, 32'hBAD, 32'hBAD, 2'd3), 1'b1,
         mk(1'b0, 4'd0, 32'h100, 32'd0, 2'd0), 1'b0);
    check_eq("full_pushpop_pending", 64'(pending), 64'd15);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, z, 1'b1, mk(1'b0, 4'(i), 32'h100 + 32'(i), 32'(i * 7), 2'd0), 1'b0);
    end

    // Random back-to-back traffic with occasional corrupted reports
    for (int i = 0; i < 80; i++) begin
      logic mv, sv;
      mv = 1'($urandom_range(0, 3) != 0);
      sv = 1'($urandom_range(0, 2) != 0);
      t  = mk(1'($urandom), 4'($urandom), $urandom, $urandom, 2'($urandom));
      if (model_q.size() > 0) begin
        b = model_q[0];
        if ($urandom_range(0, 3) == 0) b.id = b.id ^ 4'h1;
      end else begin
        b = t;
      end
      step(mv, t, sv, b, 1'b0);
    end

    // Clear mid-stream with pending=5; inputs of the clear cycle are ignored
    step(1'b0, z, 1'b1, z, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, mk(1'b0, 4'd0, 32'(i), 32'(i), 2'd0), 1'b0, z, 1'b0);
    step(1'b0, z, 1'b1, mk(1'b1, 4'd0, 32'h0, 32'h0, 2'd0), 1'b0);
    step(1'b1, mk(1'b0, 4'd0, 32'h9, 32'h9, 2'd0), 1'b0, z, 1'b0);
    check_eq("pre_clear_pending", 64'(pending), 64'd5);
    step(1'b1, a, 1'b1, mk(1'b0, 4'd0, 32'h1, 32'h1, 2'd0), 1'b1);
    check_eq("clear_idle", 64'(idle), 64'd1);
    check_eq("clear_mis_count", 64'(mismatch_count), 64'd0);

    // Saturation: 70000 back-to-back matching pairs
    a = mk(1'b1, 4'd7, 32'hABC0, 32'h1234, 2'd1);
    chk_en = 1'b0;
    step(1'b1, a, 1'b0, z, 1'b0);
    for (int i = 0; i < 69999; i++) step(1'b1, a, 1'b1, a, 1'b0);
    chk_en = 1'b1;
    step(1'b0, z, 1'b1, a, 1'b0);
    check_eq("match_saturated", 64'(match_count), 64'hFFFF);
    step(1'b0, z, 1'b0, z, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
